mesm6_intc: RTL and testbench
=============================

// Module: mesm6_intc
// PURPOSE
//  Parametrised interrupt controller for the MESM-6 core; successor of the 48-line PIC.
//  Adds the following:
//   - input synchronisers and per-source edge/level mode;
//   - CPU acknowledge handshake returning a vector;
//   - in-service tracking with nesting (only a higher-priority source may interrupt).
//  Sits between device IRQ lines and the CPU; its registers sit on the 48-bit peripheral bus.
// PARAMETERS
//  NIRQ        48  number of sources, 1..48; bit NIRQ-1 is highest priority
//  SYNC_STAGES 2   flip-flop stages on each pic_irq line, 1..3
//  VW          6   vector width, $clog2(NIRQ+1); local, not overridable
// PORTS
//  clk        in   1     clock
//  reset      in   1     asynchronous, active-high reset
//  pic_irq    in   NIRQ  raw device requests, asynchronous to clk
//  interrupt  out  1     request to CPU
//  int_ack    in   1     CPU acknowledge pulse
//  int_vec    out  VW    acknowledged vector, valid with int_vec_valid
//  int_vec_valid out 1   one-cycle strobe, cycle after int_ack
//  pic_addr   in   15    register address; [3:0] decoded
//  pic_read   in   1     read request
//  pic_write  in   1     write request
//  pic_wdata  in   48    write data; bits >= NIRQ ignored
//  pic_rdata  out  48    read data, combinational from address; unused bits 0
//  pic_done   out  1     registered pic_read|pic_write, one cycle latency
// BEHAVIOUR
//  Reset:
//   - IFS, IEC, MODE, INS and synchronisers cleared.
//   - pic_done=0, int_vec=0, int_vec_valid=0, interrupt=0.
//  Synchronisation and edge detection:
//   - s = synchronised pic_irq.
//   - Edge detection compares s against its 1-cycle delayed copy.
//  Vector numbering:
//   - vec(bit i) = NIRQ-i, so bit NIRQ-1 -> 1 and bit 0 -> NIRQ.
//   - 0 = none; a smaller vector is a higher priority.
//  IFS[i]:
//   - MODE[i]=0 (level): IFS[i] = s[i] every cycle; software writes are ignored.
//   - MODE[i]=1 (edge): set on a rising edge of s[i]; sticky.
//     Cleared by IFSCLR, IFS write, or acknowledge.
//     An edge arriving in the same cycle as a clear wins: the bit stays 1.
//  Register map (pic_addr[3:0]); wr = write, rd = read:
//   - 0 ISR   rd: highest active vector, zero-extended
//   - 1 MODE  rd/wr
//   - 2 IECCLR wr: IEC &= ~wdata
//   - 3 IECSET wr: IEC |= wdata
//   - 4 IEC   rd/wr
//   - 5 IFSCLR wr
//   - 6 IFSSET wr
//   - 7 IFS   rd/wr
//   - 8 INS   rd: in-service mask
//   - 9 EOI   wr: clears the highest-priority INS bit; wdata ignored
//   - Others: read 0, write ignored.
//  Output and vectors:
//   - active = IFS & IEC; va = vector of active; vi = vector of INS.
//   - interrupt = (va!=0) && (vi==0 || va<vi); combinational from registers.
//  Acknowledge:
//   - int_ack in a cycle where interrupt=1: next cycle int_vec=va (sampled at the ack edge)
//     and int_vec_valid=1.
//   - INS[bit] is set; IFS[bit] is cleared if the source is in edge mode.
//   - int_ack while interrupt=0: int_vec=0, int_vec_valid=1, no state change.
//  Simultaneous events:
//   - Bus write and int_ack in the same cycle: write applied, then ack clear.
//   - EOI with INS=0: no effect.
//   - Back-to-back acks are accepted every cycle.
//  Reset asserted mid-handshake: int_vec_valid is dropped immediately and all state is lost.
// STRUCTURE
//  Package mesm6_intc_pkg:
//   - register address localparams;
//   - vector-width function.
//  Sub-module mesm6_prio_enc #(N):
//   - N-bit mask -> vector and one-hot of highest set bit;
//   - instantiated twice, for active and INS.
//  Synchroniser: generate loop in this module.
// TESTING
//  1. Reset, then write IEC=1<<47, pulse pic_irq[47] (edge mode) -> interrupt rises;
//     after ack int_vec=1, IFS[47]=0, INS[47]=1, interrupt=0.
//  2. irq 0 and irq 47 pending and enabled -> ISR reads 1; ack -> vec 1; ack again -> vec 48
//     is refused (interrupt=0) until EOI, then interrupt=1 and ack -> vec 48.
//  3. Nesting: bit 10 in service (vec 38); raise bit 20 (vec 28) -> interrupt=1 -> ack;
//     EOI clears INS[20] only; INS[10] remains.
//  4. Level source bit 5 held high: ack does not clear IFS[5]; drop the line ->
//     IFS[5]=0 within SYNC_STAGES+1 cycles.
//  5. IFSCLR of bit 3 in the same cycle as a new rising edge -> IFS[3] stays 1.
//  6. NIRQ=8 build: bits 47..8 of pic_rdata read 0; bit 7 -> vec 1; every read or write
//     gives pic_done exactly one cycle later.

Source files
------------

// File: rtl/mesm6_intc_pkg.sv
// Shared definitions for the MESM-6 interrupt controller: register map and
// the vector-width helper used to size vector ports.
package mesm6_intc_pkg;

  localparam logic [3:0] REG_ISR    = 4'd0;
  localparam logic [3:0] REG_MODE   = 4'd1;
  localparam logic [3:0] REG_IECCLR = 4'd2;
  localparam logic [3:0] REG_IECSET = 4'd3;
  localparam logic [3:0] REG_IEC    = 4'd4;
  localparam logic [3:0] REG_IFSCLR = 4'd5;
  localparam logic [3:0] REG_IFSSET = 4'd6;
  localparam logic [3:0] REG_IFS    = 4'd7;
  localparam logic [3:0] REG_INS    = 4'd8;
  localparam logic [3:0] REG_EOI    = 4'd9;

  // Width needed to hold vectors 0..n (0 means "no source").
  function automatic int vec_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/mesm6_prio_enc.sv
// Priority encoder: highest set bit i of mask gives vector N-i and its one-hot;
// an empty mask gives vector 0 and an all-zero one-hot.
module mesm6_prio_enc
  import mesm6_intc_pkg::*;
#(
  parameter  int N  = 48,
  localparam int VW = vec_width(N)
) (
  input  logic [N-1:0]  mask,
  output logic [VW-1:0] vec,
  output logic [N-1:0]  onehot
);

  // Ascending scan so the highest set bit is the last one to win.
  always_comb begin
    vec    = '0;
    onehot = '0;
    for (int i = 0; i < N; i++) begin
      if (mask[i]) begin
        vec       = VW'(N - i);
        onehot    = '0;
        onehot[i] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mesm6_intc.sv
// MESM-6 interrupt controller: synchronised edge/level sources, enable and
// in-service masks, nested priority and a CPU acknowledge returning a vector.
module mesm6_intc
  import mesm6_intc_pkg::*;
#(
  parameter  int NIRQ        = 48,
  parameter  int SYNC_STAGES = 2,
  localparam int VW          = vec_width(NIRQ)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NIRQ-1:0] pic_irq,
  output logic            interrupt,
  input  logic            int_ack,
  output logic [VW-1:0]   int_vec,
  output logic            int_vec_valid,
  input  logic [14:0]     pic_addr,
  input  logic            pic_read,
  input  logic            pic_write,
  input  logic [47:0]     pic_wdata,
  output logic [47:0]     pic_rdata,
  output logic            pic_done
);

  logic [NIRQ-1:0] s;
  logic [NIRQ-1:0] s_dly_reg;
  logic [NIRQ-1:0] rise;

  logic [NIRQ-1:0] ifs_reg, ifs_next, ifs_sw;
  logic [NIRQ-1:0] iec_reg, iec_next;
  logic [NIRQ-1:0] mode_reg, mode_next;
  logic [NIRQ-1:0] ins_reg, ins_next;

  logic [NIRQ-1:0] active;
  logic [NIRQ-1:0] act_onehot;
  logic [NIRQ-1:0] ins_onehot;
  logic [VW-1:0]   va;
  logic [VW-1:0]   vi;

  logic [NIRQ-1:0] wdata;
  logic [3:0]      reg_sel;
  logic            ack_take;
  logic            unused_bits;

  assign wdata       = pic_wdata[NIRQ-1:0];
  assign reg_sel     = pic_addr[3:0];
  assign unused_bits = ^{pic_addr[14:4], pic_wdata};

  // Per-source synchroniser chain plus one more flop for edge detection.
  generate
    for (genvar gi = 0; gi < NIRQ; gi++) begin : g_sync
      logic [SYNC_STAGES-1:0] chain_reg;

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          chain_reg    <= '0;
          s_dly_reg[gi] <= 1'b0;
        end else begin
          chain_reg    <= SYNC_STAGES'({chain_reg, pic_irq[gi]});
          s_dly_reg[gi] <= chain_reg[SYNC_STAGES-1];
        end
      end

      assign s[gi] = chain_reg[SYNC_STAGES-1];
    end
  endgenerate

  assign rise   = s & ~s_dly_reg;
  assign active = ifs_reg & iec_reg;

  mesm6_prio_enc #(.N(NIRQ)) u_enc_active (
    .mask   (active),
    .vec    (va),
    .onehot (act_onehot)
  );

  mesm6_prio_enc #(.N(NIRQ)) u_enc_ins (
    .mask   (ins_reg),
    .vec    (vi),
    .onehot (ins_onehot)
  );

  // Smaller vector means higher priority; only a strictly higher one may nest.
  assign interrupt = (va != '0) && ((vi == '0) || (va < vi));
  assign ack_take  = int_ack & interrupt;

  always_comb begin
    mode_next = mode_reg;
    iec_next  = iec_reg;
    ifs_sw    = ifs_reg;
    ins_next  = ins_reg;
    if (pic_write) begin
      case (reg_sel)
        REG_MODE:   mode_next = wdata;
        REG_IECCLR: iec_next  = iec_reg & ~wdata;
        REG_IECSET: iec_next  = iec_reg | wdata;
        REG_IEC:    iec_next  = wdata;
        REG_IFSCLR: ifs_sw    = ifs_reg & ~wdata;
        REG_IFSSET: ifs_sw    = ifs_reg | wdata;
        REG_IFS:    ifs_sw    = wdata;
        REG_EOI:    ins_next  = ins_reg & ~ins_onehot;
        default:    ;
      endcase
    end
    // Acknowledge acts after the bus write of the same cycle.
    if (ack_take) begin
      ins_next = ins_next | act_onehot;
      ifs_sw   = ifs_sw & ~(act_onehot & mode_reg);
    end
    // Edge sources: a fresh edge beats any clear. Level sources follow s.
    ifs_next = (mode_reg & (ifs_sw | rise)) | (~mode_reg & s);
  end

  always_comb begin
    pic_rdata = '0;
    case (reg_sel)
      REG_ISR:  pic_rdata = 48'(va);
      REG_MODE: pic_rdata = 48'(mode_reg);
      REG_IEC:  pic_rdata = 48'(iec_reg);
      REG_IFS:  pic_rdata = 48'(ifs_reg);
      REG_INS:  pic_rdata = 48'(ins_reg);
      default:  pic_rdata = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ifs_reg       <= '0;
      iec_reg       <= '0;
      mode_reg      <= '0;
      ins_reg       <= '0;
      pic_done      <= 1'b0;
      int_vec       <= '0;
      int_vec_valid <= 1'b0;
    end else begin
      ifs_reg       <= ifs_next;
      iec_reg       <= iec_next;
      mode_reg      <= mode_next;
      ins_reg       <= ins_next;
      pic_done      <= pic_read | pic_write;
      int_vec_valid <= int_ack;
      if (int_ack) begin
        int_vec <= ack_take ? va : '0;
      end
    end
  end

endmodule

// File: tb/tb_mesm6_intc.sv
// Bench for mesm6_intc: directed scenarios plus random traffic checked against
// a per-source reference model, with acknowledge vectors matched via a queue.
`timescale 1ns/1ps
module tb_mesm6_intc;
  import mesm6_intc_pkg::*;

  localparam int N = 48;
  localparam int S = 2;

  logic        clk;
  logic        rst;
  logic [N-1:0] pic_irq;
  logic        interrupt;
  logic        int_ack;
  logic [5:0]  int_vec;
  logic        int_vec_valid;
  logic [14:0] pic_addr;
  logic        pic_read;
  logic        pic_write;
  logic [47:0] pic_wdata;
  logic [47:0] pic_rdata;
  logic        pic_done;

  logic [7:0]  irq_8;
  logic        intr_8;
  logic        ack_8;
  logic [3:0]  vec_8;
  logic        vv_8;
  logic [14:0] addr_8;
  logic        rd_8;
  logic        wr_8;
  logic [47:0] wdata_8;
  logic [47:0] rdata_8;
  logic        done_8;

  int tests  = 0;
  int errors = 0;

  mesm6_intc #(.NIRQ(N), .SYNC_STAGES(S)) dut (
    .clk           (clk),
    .reset         (rst),
    .pic_irq       (pic_irq),
    .interrupt     (interrupt),
    .int_ack       (int_ack),
    .int_vec       (int_vec),
    .int_vec_valid (int_vec_valid),
    .pic_addr      (pic_addr),
    .pic_read      (pic_read),
    .pic_write     (pic_write),
    .pic_wdata     (pic_wdata),
    .pic_rdata     (pic_rdata),
    .pic_done      (pic_done)
  );

  mesm6_intc #(.NIRQ(8), .SYNC_STAGES(S)) dut8 (
    .clk           (clk),
    .reset         (rst),
    .pic_irq       (irq_8),
    .interrupt     (intr_8),
    .int_ack       (ack_8),
    .int_vec       (vec_8),
    .int_vec_valid (vv_8),
    .pic_addr      (addr_8),
    .pic_read      (rd_8),
    .pic_write     (wr_8),
    .pic_wdata     (wdata_8),
    .pic_rdata     (rdata_8),
    .pic_done      (done_8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [N-1:0] m_ifs, m_iec, m_mode, m_ins;
  logic [N-1:0] hist[$];
  bit           m_done;
  int           exp_q[$];

  function automatic int top_vec(input logic [N-1:0] m);
    for (int i = N - 1; i >= 0; i--)
      if (m[i]) return N - i;
    return 0;
  endfunction

  function automatic bit m_intr();
    int va = top_vec(m_ifs & m_iec);
    int vi = top_vec(m_ins);
    return (va != 0) && (vi == 0 || va < vi);
  endfunction

  function automatic logic [47:0] m_read(input logic [3:0] a);
    case (a)
      REG_ISR:  return 48'(top_vec(m_ifs & m_iec));
      REG_MODE: return m_mode;
      REG_IEC:  return m_iec;
      REG_IFS:  return m_ifs;
      REG_INS:  return m_ins;
      default:  return '0;
    endcase
  endfunction

  task automatic m_reset();
    m_ifs = '0; m_iec = '0; m_mode = '0; m_ins = '0; m_done = 1'b0;
    hist.delete();
    repeat (S + 1) hist.push_back('0);
    exp_q.delete();
  endtask

  task automatic m_step();
    logic [N-1:0] s, sd, w, nifs, nins, nmode, niec;
    int va, vi;
    bit intr;
    s = hist[1];
    sd = hist[0];
    w = pic_wdata;
    va = top_vec(m_ifs & m_iec);
    vi = top_vec(m_ins);
    intr = m_intr();
    nifs = m_ifs; nins = m_ins; nmode = m_mode; niec = m_iec;
    if (pic_write) begin
      case (pic_addr[3:0])
        REG_MODE:   nmode = w;
        REG_IECCLR: niec = niec & ~w;
        REG_IECSET: niec = niec | w;
        REG_IEC:    niec = w;
        REG_IFSCLR: nifs = nifs & ~w;
        REG_IFSSET: nifs = nifs | w;
        REG_IFS:    nifs = w;
        REG_EOI:    if (vi != 0) nins[N - vi] = 1'b0;
        default: ;
      endcase
    end
    if (int_ack) begin
      exp_q.push_back(intr ? va : 0);
      if (intr) begin
        nins[N - va] = 1'b1;
        if (m_mode[N - va]) nifs[N - va] = 1'b0;
      end
    end
    for (int i = 0; i < N; i++) begin
      if (!m_mode[i]) nifs[i] = s[i];
      else if (s[i] && !sd[i]) nifs[i] = 1'b1;
    end
    m_ifs = nifs; m_ins = nins; m_mode = nmode; m_iec = niec;
    m_done = pic_read | pic_write;
    hist.push_back(pic_irq);
    void'(hist.pop_front());
  endtask

  initial begin
    m_reset();
    forever begin
      @(posedge clk or posedge rst);
      if (rst) m_reset();
      else m_step();
    end
  end

  // ---------------- monitor / scoreboard ----------------
  initial begin
    int e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        chk("interrupt", 64'(interrupt), 64'(m_intr()));
        chk("pic_done", 64'(pic_done), 64'(m_done));
        chk("pic_rdata", 64'(pic_rdata), 64'(m_read(pic_addr[3:0])));
        if (int_vec_valid || exp_q.size() != 0) begin
          if (exp_q.size() == 0) begin
            chk("vec_unexpected", 64'(int_vec_valid), 64'(0));
          end else begin
            e = exp_q.pop_front();
            chk("int_vec_valid", 64'(int_vec_valid), 64'(1));
            chk("int_vec", 64'(int_vec), 64'(e));
          end
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus helpers ----------------
  function automatic logic [47:0] rnd48();
    return {16'($urandom), 32'($urandom)};
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [3:0] a, input logic [47:0] d);
    pic_addr = {11'($urandom), a};
    pic_wdata = d;
    pic_write = 1'b1;
    cyc();
    pic_write = 1'b0;
  endtask

  task automatic rd(input string name, input logic [3:0] a, input logic [47:0] exp);
    pic_addr = {11'($urandom), a};
    pic_read = 1'b1;
    @(negedge clk);
    chk(name, 64'(pic_rdata), 64'(exp));
    cyc();
    pic_read = 1'b0;
  endtask

  task automatic ack(input string name, input int exp_v);
    int_ack = 1'b1;
    cyc();
    int_ack = 1'b0;
    chk({name, "_valid"}, 64'(int_vec_valid), 64'(1));
    chk(name, 64'(int_vec), 64'(exp_v));
  endtask

  task automatic pulse(input logic [N-1:0] mask);
    pic_irq = pic_irq | mask;
    repeat (S + 2) cyc();
    pic_irq = pic_irq & ~mask;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int op;
    rst = 1'b1;
    pic_irq = '0; int_ack = 1'b0; pic_addr = '0; pic_read = 1'b0;
    pic_write = 1'b0; pic_wdata = '0;
    irq_8 = '0; ack_8 = 1'b0; addr_8 = '0; rd_8 = 1'b0; wr_8 = 1'b0; wdata_8 = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    chk("rst_interrupt", 64'(interrupt), 64'(0));
    chk("rst_vec_valid", 64'(int_vec_valid), 64'(0));
    chk("rst_int_vec", 64'(int_vec), 64'(0));
    chk("rst_done", 64'(pic_done), 64'(0));
    chk("rst_n8_done", 64'(done_8), 64'(0));
    rd("rst_ifs", REG_IFS, '0);
    rd("rst_ins", REG_INS, '0);

    // 1: single edge source, highest priority
    wr(REG_MODE, 48'(1) << 47);
    wr(REG_IEC, 48'(1) << 47);
    pulse(48'(1) << 47);
    chk("t1_interrupt", 64'(interrupt), 64'(1));
    ack("t1_vec", 1);
    chk("t1_int_after", 64'(interrupt), 64'(0));
    rd("t1_ifs", REG_IFS, '0);
    rd("t1_ins", REG_INS, 48'(1) << 47);
    wr(REG_EOI, rnd48());
    rd("t1_ins_eoi", REG_INS, '0);

    // 2: two pending; lower one refused until EOI
    wr(REG_MODE, '1);
    wr(REG_IEC, (48'(1) << 47) | 48'(1));
    pulse((48'(1) << 47) | 48'(1));
    rd("t2_isr", REG_ISR, 48'(1));
    ack("t2_vec1", 1);
    chk("t2_blocked", 64'(interrupt), 64'(0));
    ack("t2_refused", 0);
    wr(REG_EOI, '0);
    chk("t2_unblocked", 64'(interrupt), 64'(1));
    ack("t2_vec48", 48);
    wr(REG_EOI, '0);
    rd("t2_ins", REG_INS, '0);

    // 3: nesting
    wr(REG_IEC, (48'(1) << 10) | (48'(1) << 20));
    pulse(48'(1) << 10);
    ack("t3_vec38", 38);
    pulse(48'(1) << 20);
    chk("t3_nest_int", 64'(interrupt), 64'(1));
    ack("t3_vec28", 28);
    wr(REG_EOI, '0);
    rd("t3_ins_outer", REG_INS, 48'(1) << 10);
    wr(REG_EOI, '0);
    rd("t3_ins_none", REG_INS, '0);

    // 4: level source
    wr(REG_MODE, ~(48'(1) << 5));
    wr(REG_IEC, 48'(1) << 5);
    pic_irq[5] = 1'b1;
    repeat (S + 2) cyc();
    chk("t4_interrupt", 64'(interrupt), 64'(1));
    ack("t4_vec43", 43);
    rd("t4_ifs_held", REG_IFS, 48'(1) << 5);
    wr(REG_EOI, '0);
    pic_irq[5] = 1'b0;
    repeat (S + 1) cyc();
    rd("t4_ifs_drop", REG_IFS, '0);

    // 5: edge beats clear in the same cycle
    wr(REG_MODE, '1);
    wr(REG_IEC, '0);
    pic_irq[3] = 1'b1;
    repeat (S) cyc();
    wr(REG_IFSCLR, 48'(1) << 3);
    rd("t5_edge_wins", REG_IFS, 48'(1) << 3);
    wr(REG_IFSCLR, 48'(1) << 3);
    rd("t5_clear", REG_IFS, '0);
    pic_irq[3] = 1'b0;

    // reset in the middle of a handshake
    wr(REG_IFSSET, 48'(1) << 3);
    wr(REG_IEC, 48'(1) << 3);
    ack("rst_mid_vec45", 45);
    rst = 1'b1;
    #1;
    chk("rst_mid_valid", 64'(int_vec_valid), 64'(0));
    chk("rst_mid_int", 64'(interrupt), 64'(0));
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    rd("rst_mid_iec", REG_IEC, '0);

    // random traffic against the model
    for (int n = 0; n < 2000; n++) begin
      pic_irq = pic_irq ^ (rnd48() & rnd48() & rnd48() & rnd48());
      op = int'($urandom_range(0, 9));
      pic_write = (op < 4);
      pic_read = (op >= 4 && op < 6);
      pic_addr = 15'($urandom_range(0, 32767));
      pic_wdata = rnd48();
      int_ack = ($urandom_range(0, 2) == 0);
      cyc();
    end
    pic_write = 1'b0; pic_read = 1'b0; int_ack = 1'b0;
    repeat (4) cyc();
    chk("scoreboard_drain", 64'(exp_q.size()), 64'(0));

    // 6: NIRQ=8 build
    addr_8 = {11'h7FF, REG_IEC}; wdata_8 = '1; wr_8 = 1'b1;
    cyc();
    wr_8 = 1'b0;
    chk("n8_done_wr", 64'(done_8), 64'(1));
    cyc();
    chk("n8_done_idle", 64'(done_8), 64'(0));
    rd_8 = 1'b1;
    #1 chk("n8_iec", 64'(rdata_8), 64'(48'hFF));
    cyc();
    rd_8 = 1'b0;
    chk("n8_done_rd", 64'(done_8), 64'(1));
    addr_8 = {11'h555, REG_MODE}; wdata_8 = '1; wr_8 = 1'b1;
    cyc();
    wr_8 = 1'b0;
    #1 chk("n8_mode", 64'(rdata_8), 64'(48'hFF));
    irq_8[7] = 1'b1;
    repeat (S + 2) cyc();
    chk("n8_interrupt", 64'(intr_8), 64'(1));
    addr_8 = {11'h0, REG_ISR};
    #1 chk("n8_isr", 64'(rdata_8), 64'(1));
    ack_8 = 1'b1;
    cyc();
    ack_8 = 1'b0;
    chk("n8_vec_valid", 64'(vv_8), 64'(1));
    chk("n8_vec", 64'(vec_8), 64'(1));
    chk("n8_int_after", 64'(intr_8), 64'(0));
    cyc();
    chk("n8_valid_drop", 64'(vv_8), 64'(0));

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
